pci_target_bfm: RTL

PCI_TARGET_BFM -- requirements
Module: pci_target_bfm

---
 rtl/pci_target_bfm.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pci_target_bfm.sv
// pci_target_bfm -- behavioural PCI memory target with a 64 x 32-bit memory
// window at BASE_ADDR.
//
// Parameters
//   BASE_ADDR   window base, 256-byte aligned (AD[31:8] decode)
//   WAIT_STATES wait states before the first data phase (0..3)
//   BURST_LIMIT data phases accepted before disconnect-with-data (1..64)
//
// Ports
//   CLK                      PCI clock, all logic on the rising edge
//   RST                      synchronous active-low reset
//   FRAME_in, IRDY_in        sampled FRAME#, IRDY#
//   AD_in[31:0], CBE_in[3:0] sampled AD and C/BE#
//   AD_out[31:0], AD_en      read data and its drive enable (active low)
//   DEVSEL/TRDY/STOP/PAR_out target control outputs
//   DEVSEL/TRDY/STOP/PAR_en  drive enables for the above (active low)
//
// Optional build macro
//   PCI_TGT_PARITY_EN        when defined, PAR is generated one cycle after
//                            each cycle in which the target drives AD;
//                            otherwise PAR_out and PAR_en stay high.
module pci_target_bfm #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_STATES = 1,
  parameter int          BURST_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME_in,
  input  logic        IRDY_in,
  input  logic [31:0] AD_in,
  input  logic [3:0]  CBE_in,
  output logic [31:0] AD_out,
  output logic        AD_en,
  output logic        DEVSEL_out,
  output logic        TRDY_out,
  output logic        STOP_out,
  output logic        PAR_out,
  output logic        DEVSEL_en,
  output logic        TRDY_en,
  output logic        STOP_en,
  output logic        PAR_en
);

  localparam logic [3:0] CMD_RD = 4'b0110;
  localparam logic [3:0] CMD_WR = 4'b0111;
  localparam logic [6:0] BL     = 7'(BURST_LIMIT);
  localparam logic [2:0] WS_WR  = 3'(WAIT_STATES);
  // Reads spend one extra cycle on the AD turnaround before TRDY.
  localparam logic [2:0] WS_RD  = 3'(WAIT_STATES + 1);

  typedef enum logic [2:0] {IDLE, WAIT, XFER, DISC, TURN} state_t;

  state_t      state;
  logic [31:0] mem [64];
  logic [5:0]  idx;
  logic        is_rd;
  logic [2:0]  wcnt;
  logic [6:0]  nph;      // completed data phases in this burst
  logic        frame_q;  // FRAME_in one cycle ago, for address-phase edge

  logic        claim, done, abandon, to_turn;
  logic [5:0]  idx_nxt;
  logic        unused_ad;

  assign unused_ad = ^AD_in[1:0];

  assign claim   = (state == IDLE) && !FRAME_in && frame_q &&
                   (AD_in[31:8] == BASE_ADDR[31:8]) &&
                   ((CBE_in == CMD_RD) || (CBE_in == CMD_WR));
  assign done    = (state == XFER) && !TRDY_out && !IRDY_in;
  assign abandon = FRAME_in && IRDY_in;
  assign idx_nxt = done ? idx + 6'd1 : idx;   // 6-bit index wraps 63->0

  // Every path that ends the transaction funnels through one override below.
  assign to_turn = ((state == WAIT) && abandon) ||
                   ((state == XFER) && (done ? FRAME_in : abandon)) ||
                   ((state == DISC) && FRAME_in);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      idx        <= '0;
      is_rd      <= 1'b0;
      wcnt       <= '0;
      nph        <= '0;
      frame_q    <= 1'b1;
      AD_out     <= '0;
      AD_en      <= 1'b1;
      DEVSEL_out <= 1'b1;
      DEVSEL_en  <= 1'b1;
      TRDY_out   <= 1'b1;
      TRDY_en    <= 1'b1;
      STOP_out   <= 1'b1;
      STOP_en    <= 1'b1;
    end else begin
      frame_q <= FRAME_in;

      // Read data tracks the index that will be current after this edge.
      if ((state == WAIT) || (state == XFER) || (state == DISC)) begin
        idx    <= idx_nxt;
        AD_out <= is_rd ? mem[idx_nxt] : '0;
      end

      case (state)
        IDLE: begin
          if (claim) begin
            is_rd      <= (CBE_in == CMD_RD);
            idx        <= AD_in[7:2];
            nph        <= '0;
            DEVSEL_out <= 1'b0;
            DEVSEL_en  <= 1'b0;
            TRDY_en    <= 1'b0;
            STOP_en    <= 1'b0;
            TRDY_out   <= 1'b1;
            STOP_out   <= 1'b1;
            if ((CBE_in == CMD_WR) && (WS_WR == 3'd0)) begin
              state    <= XFER;
              TRDY_out <= 1'b0;
              STOP_out <= (BL != 7'd1);
            end else begin
              state <= WAIT;
              wcnt  <= (CBE_in == CMD_RD) ? WS_RD : WS_WR;
            end
          end
        end
        WAIT: begin
          if (is_rd) AD_en <= 1'b0;
          wcnt <= wcnt - 3'd1;
          if (wcnt == 3'd1) begin
            state    <= XFER;
            TRDY_out <= 1'b0;
            STOP_out <= (BL != 7'd1);
          end
        end
        XFER: begin
          if (done) begin
            nph <= nph + 7'd1;
            if (nph + 7'd1 == BL) begin
              // Disconnect-with-data phase just completed.
              state    <= DISC;
              TRDY_out <= 1'b1;
              AD_en    <= 1'b1;
            end else begin
              STOP_out <= (nph + 7'd2 != BL);
            end
          end
        end
        DISC: ;
        TURN: begin
          state     <= IDLE;
          DEVSEL_en <= 1'b1;
          TRDY_en   <= 1'b1;
          STOP_en   <= 1'b1;
          AD_en     <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // One cycle of driven-high control before the enables release.
      if (to_turn) begin
        state      <= TURN;
        DEVSEL_out <= 1'b1;
        TRDY_out   <= 1'b1;
        STOP_out   <= 1'b1;
        AD_en      <= 1'b1;
        AD_out     <= '0;
      end
    end
  end

  // Memory has no reset so contents survive RST; a reset edge blocks the write.
  always_ff @(posedge CLK) begin
    if (RST && done && !is_rd) begin
      for (int b = 0; b < 4; b++)
        if (!CBE_in[b]) mem[idx][8*b +: 8] <= AD_in[8*b +: 8];
    end
  end

`ifdef PCI_TGT_PARITY_EN
  // PAR covers the AD/CBE pair of the previous cycle, so it lags AD_en by one.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      PAR_out <= 1'b1;
      PAR_en  <= 1'b1;
    end else begin
      PAR_en  <= AD_en;
      PAR_out <= AD_en ? 1'b1 : ^{AD_out, CBE_in};
    end
  end
`else
  assign PAR_out = 1'b1;
  assign PAR_en  = 1'b1;
`endif

endmodule
